sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Parametrised shared system bus for intermodular communication. Replaces
//  static tie-offs with a live single-transaction bus. N_MST masters
//  (CPU, DMA, VGA fetch, ...) are round-robin arbitrated. The granted address
//  is decoded onto N_SLV slaves (SDRAM ctrl, GPIO, gsensor, ...). A per-access
//  timeout returns an error, so a dead slave never locks the bus.
// PARAMETERS
//  N_MST    4   number of masters (>=1)
//  N_SLV    4   number of slaves (>=1, <=2**SEL_W)
//  ADDR_W   24  master address width
//  SEL_W    4   top address bits used as slave index
//  DATA_W   16  data width
//  TIMEOUT  255 cycles in XFER before error; 0 disables timeout
// PORTS
//  clk1_50  in   1              bus clock, rising edge
//  rst_     in   1              async reset, active low
//  m_req    in   N_MST          per-master request, held until m_ack
//  m_we     in   N_MST          per-master write(1)/read(0)
//  m_addr   in   N_MST*ADDR_W   per-master address, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata  in   N_MST*DATA_W   per-master write data
//  m_ack    out  N_MST          one-cycle completion pulse to granted master
//  m_err    out  1              error flag, valid with m_ack
//  m_rdata  out  DATA_W         read data, valid with m_ack
//  s_req    out  N_SLV          one-hot slave request
//  s_we     out  1              write enable to slaves
//  s_addr   out  ADDR_W-SEL_W   slave-local address
//  s_wdata  out  DATA_W         write data to slaves
//  s_ack    in   N_SLV          slave completion, sampled only from the selected slave
//  s_rdata  in   N_SLV*DATA_W   per-slave read data, valid with s_ack
//  busy     out  1              1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_=0):
//   - state=IDLE; rr pointer=0.
//   - All outputs 0; captured addr/wdata/we/grant cleared.
//  FSM: IDLE -> XFER -> DONE -> IDLE; decode error goes IDLE -> DONE.
//  IDLE:
//   - If any m_req, grant the first requester at or after rr pointer, mod N_MST.
//   - Capture its m_we, m_addr and m_wdata in registers.
//   - Set rr = grant+1 mod N_MST.
//   - sel = addr[ADDR_W-1 -: SEL_W].
//   - If sel >= N_SLV, go to DONE with err=1; else go to XFER.
//  XFER:
//   - s_req[sel]=1; s_we, s_addr=addr[ADDR_W-SEL_W-1:0] and s_wdata come from
//     registers and are stable for the whole state.
//   - On s_ack[sel]=1: capture s_rdata[sel] (0 on write) and go to DONE, err=0.
//   - s_req drops the cycle after ack.
//   - Timeout counter starts at 0 on XFER entry and increments each XFER cycle.
//   - If counter==TIMEOUT-1 with no ack: go to DONE, err=1, rdata=0.
//   - Ack wins over timeout in the same cycle.
//  DONE: m_ack[grant]=1, m_err and m_rdata driven, for exactly 1 cycle, then IDLE.
//  Latency from IDLE sampling m_req:
//   - s_req asserts next cycle.
//   - Zero-wait slave: m_ack 2 cycles after sample.
//   - Decode error: m_ack 1 cycle after sample.
//  Handshake rules:
//   - Master drops m_req the cycle after seeing m_ack. m_req still high when
//     IDLE samples is a new transaction.
//   - m_req dropped mid-transaction is ignored; the access completes and
//     m_ack is still pulsed.
//   - s_ack from non-selected slaves is ignored; s_ack outside XFER is ignored.
//  Arbitration:
//   - Simultaneous requests: lowest index at or after rr wins.
//   - No master waits more than N_MST-1 transactions.
//   - N_MST=1 makes the rr pointer a constant 0.
//  Outputs are registered (no combinational path m_* -> s_* or s_* -> m_*),
//  except busy, which is decoded from the state register.
// TESTING
//  1. Single read, m0 addr 0x100042 (slave 1), s_ack same cycle as s_req,
//     rdata 0xBEEF -> s_req=0b0010, s_addr=0x00042; m_ack[0] 2 cycles after
//     sample, m_rdata=0xBEEF, m_err=0.
//  2. m0..m3 request together and hold -> grants 0,1,2,3,0.
//     - m2 alone after grant 1 -> m2 granted next.
//  3. Write m1 addr 0x3000FF wdata 0x1234, slave 3 acks after 5 wait cycles
//     -> s_wdata=0x1234, s_we=1 stable 6 cycles; m_ack[1] 1 cycle after s_ack.
//  4. Addr 0x500000 with N_SLV=4 -> no s_req; m_ack 1 cycle after sample,
//     m_err=1.
//  5. TIMEOUT=8, slave never acks -> s_req high 8 cycles then low; m_ack with
//     m_err=1, m_rdata=0.
//     - Repeat with ack on cycle 8 -> no error.
//  6. rst_ low mid-XFER -> s_req, busy, m_ack=0 immediately; rr=0.
//     - After release, simultaneous m1 and m3 -> m1 granted.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: single-transaction shared system bus.
// N_MST masters are round-robin arbitrated; the granted request is decoded
// onto one of N_SLV slaves by the top SEL_W address bits. A per-access
// timeout answers with an error, so a dead slave can never lock the bus.
// All m_*/s_* outputs come straight from registers; only busy is decoded
// from the state register.
module sysbus_arbiter #(
    parameter int N_MST   = 4,
    parameter int N_SLV   = 4,
    parameter int ADDR_W  = 24,
    parameter int SEL_W   = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk1_50,
    input  logic                    rst_,
    input  logic [N_MST-1:0]        m_req,
    input  logic [N_MST-1:0]        m_we,
    input  logic [N_MST*ADDR_W-1:0] m_addr,
    input  logic [N_MST*DATA_W-1:0] m_wdata,
    output logic [N_MST-1:0]        m_ack,
    output logic                    m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [N_SLV-1:0]        s_req,
    output logic                    s_we,
    output logic [ADDR_W-SEL_W-1:0] s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_ack,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    output logic                    busy
);

    localparam int MST_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int LOC_W = ADDR_W - SEL_W;
    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [MST_W:0]   MST_CNT  = (MST_W + 1)'(N_MST);
    localparam logic [SEL_W:0]   SLV_CNT  = (SEL_W + 1)'(N_SLV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [MST_W-1:0]    r_rr;
    logic [MST_W-1:0]    r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_SLV-1:0]    r_s_req;
    logic [N_MST-1:0]    r_m_ack;
    logic                r_m_err;
    logic [DATA_W-1:0]   r_m_rdata;

    logic [N_MST-1:0]    w_req_rot;
    logic                w_found;
    logic [MST_W-1:0]    w_off;
    logic [MST_W:0]      w_gnt_sum;
    logic [MST_W-1:0]    w_gnt;
    logic [MST_W:0]      w_rr_sum;
    logic [MST_W-1:0]    w_rr_nxt;
    logic                w_m_we;
    logic [ADDR_W-1:0]   w_m_addr;
    logic [DATA_W-1:0]   w_m_wdata;
    logic [SEL_W-1:0]    w_in_sel;
    logic                w_dec_err;
    logic [SEL_W-1:0]    w_sel;
    logic                w_ack_sel;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_timeout;

    // One-hot master vector for a grant index.
    function automatic logic [N_MST-1:0] mst_onehot(input logic [MST_W-1:0] idx);
        logic [N_MST-1:0] v;
        v = '0;
        for (int k = 0; k < N_MST; k++) begin
            v[k] = (MST_W'(k) == idx);
        end
        return v;
    endfunction

    // One-hot slave vector for a select index (only called with sel < N_SLV).
    function automatic logic [N_SLV-1:0] slv_onehot(input logic [SEL_W-1:0] idx);
        logic [N_SLV-1:0] v;
        v = '0;
        for (int k = 0; k < N_SLV; k++) begin
            v[k] = (SEL_W'(k) == idx);
        end
        return v;
    endfunction

    // Round-robin pick: rotate requests so the rr pointer sits at bit 0,
    // take the lowest set bit, then rotate the offset back into an index.
    always_comb begin
        w_req_rot = N_MST'({m_req, m_req} >> r_rr);
        w_found   = 1'b0;
        w_off     = '0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found = 1'b1;
                w_off   = MST_W'(k);
            end
        end
        w_gnt_sum = {1'b0, r_rr} + {1'b0, w_off};
        if (w_gnt_sum >= MST_CNT) begin
            w_gnt_sum = w_gnt_sum - MST_CNT;
        end
        w_gnt    = w_gnt_sum[MST_W-1:0];
        w_rr_sum = {1'b0, w_gnt} + (MST_W + 1)'(1);
        if (w_rr_sum >= MST_CNT) begin
            w_rr_sum = '0;
        end
        w_rr_nxt = w_rr_sum[MST_W-1:0];
    end

    // Select the granted master's request fields.
    always_comb begin
        w_m_we    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (MST_W'(k) == w_gnt) begin
                w_m_we    = m_we[k];
                w_m_addr  = m_addr[k*ADDR_W +: ADDR_W];
                w_m_wdata = m_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_in_sel  = w_m_addr[ADDR_W-1 -: SEL_W];
    assign w_dec_err = ({1'b0, w_in_sel} >= SLV_CNT);
    assign w_sel     = r_addr[ADDR_W-1 -: SEL_W];

    // Only the selected slave's ack and read data are looked at.
    always_comb begin
        w_ack_sel   = 1'b0;
        w_rdata_sel = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (SEL_W'(k) == w_sel) begin
                w_ack_sel   = s_ack[k];
                w_rdata_sel = s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // Bus FSM: arbitration and capture in IDLE, slave handshake in XFER,
    // one-cycle master response in DONE; all bus outputs registered here.
    always_ff @(posedge clk1_50 or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_IDLE;
            r_rr      <= '0;
            r_grant   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_s_req   <= '0;
            r_m_ack   <= '0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_gnt;
                        r_we    <= w_m_we;
                        r_addr  <= w_m_addr;
                        r_wdata <= w_m_wdata;
                        r_rr    <= w_rr_nxt;
                        r_cnt   <= '0;
                        if (w_dec_err) begin
                            r_state   <= ST_DONE;
                            r_m_ack   <= mst_onehot(w_gnt);
                            r_m_err   <= 1'b1;
                            r_m_rdata <= '0;
                        end else begin
                            r_state <= ST_XFER;
                            r_s_req <= slv_onehot(w_in_sel);
                        end
                    end
                end
                ST_XFER: begin
                    // An ack in the last counted cycle still completes cleanly.
                    if (w_ack_sel) begin
                        r_state   <= ST_DONE;
                        r_s_req   <= '0;
                        r_m_ack   <= mst_onehot(r_grant);
                        r_m_err   <= 1'b0;
                        r_m_rdata <= r_we ? '0 : w_rdata_sel;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_s_req   <= '0;
                        r_m_ack   <= mst_onehot(r_grant);
                        r_m_err   <= 1'b1;
                        r_m_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_m_ack   <= '0;
                    r_m_err   <= 1'b0;
                    r_m_rdata <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack   = r_m_ack;
    assign m_err   = r_m_err;
    assign m_rdata = r_m_rdata;
    assign s_req   = r_s_req;
    assign s_we    = r_we;
    assign s_addr  = r_addr[LOC_W-1:0];
    assign s_wdata = r_wdata;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: fixed vectors, hand-written arbitration/reset
// sequences and a randomized phase against a transaction-level model.
module tb_sysbus_arbiter;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 24;
    localparam int SW = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic                 clk1_50 = 1'b0;
    logic                 rst_    = 1'b1;
    logic [NM-1:0]        m_req;
    logic [NM-1:0]        m_we;
    logic [NM*AW-1:0]     m_addr;
    logic [NM*DW-1:0]     m_wdata;
    logic [NM-1:0]        m_ack;
    logic                 m_err;
    logic [DW-1:0]        m_rdata;
    logic [NS-1:0]        s_req;
    logic                 s_we;
    logic [AW-SW-1:0]     s_addr;
    logic [DW-1:0]        s_wdata;
    logic [NS-1:0]        s_ack;
    logic [NS*DW-1:0]     s_rdata;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    // Slave models: ack once s_req has been high for slv_wait completed cycles.
    int            slv_wait[NS];
    logic [DW-1:0] slv_data[NS];
    int            slv_cnt[NS];
    logic [NS-1:0] ack_force = '0;

    typedef struct {
        int            mst;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wt;
        logic [DW-1:0] sdata;
        logic [NS-1:0] e_sreq;
        logic [19:0]   e_saddr;
        logic          e_err;
        logic [DW-1:0] e_rdata;
        int            e_lat;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    sysbus_arbiter #(
        .N_MST(NM), .N_SLV(NS), .ADDR_W(AW), .SEL_W(SW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk1_50(clk1_50), .rst_(rst_),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy)
    );

    always #10 clk1_50 = ~clk1_50;

    always @(posedge clk1_50) begin
        for (int k = 0; k < NS; k++) begin
            slv_cnt[k] <= s_req[k] ? slv_cnt[k] + 1 : 0;
        end
    end

    always_comb begin
        s_ack   = ack_force;
        s_rdata = '0;
        for (int k = 0; k < NS; k++) begin
            if (s_req[k] && (slv_cnt[k] >= slv_wait[k])) s_ack[k] = 1'b1;
            s_rdata[k*DW +: DW] = slv_data[k];
        end
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_mst(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_we[i]             = we;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic set_slaves(input int w, input logic [DW-1:0] d);
        for (int k = 0; k < NS; k++) begin
            slv_wait[k] = w;
            slv_data[k] = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk1_50);
        rst_  = 1'b0;
        m_req = '0;
        @(negedge clk1_50);
        @(negedge clk1_50);
        rst_ = 1'b1;
    endtask

    // Called on a negedge with requests already applied while the bus is idle.
    // Watches the slave side every cycle and checks the master response.
    task automatic wait_ack(input string nm, input logic [NM-1:0] e_ack, input logic e_err,
                            input logic [DW-1:0] e_rdata, input int e_lat,
                            input logic [NS-1:0] e_sreq, input logic [19:0] e_saddr,
                            input logic e_swe, input logic [DW-1:0] e_swdata);
        int n;
        int nx;
        bit got;
        n   = 0;
        nx  = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk1_50);
            n++;
            if (m_ack != '0) begin
                got = 1'b1;
            end else if (s_req != '0) begin
                nx++;
                chk($sformatf("%s_sbus", nm), {s_req, s_we, s_addr, s_wdata},
                    {e_sreq, e_swe, e_saddr, e_swdata});
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_noack: no m_ack within %0d cycles, expected after %0d", nm, n, e_lat);
        end else begin
            chk($sformatf("%s_mack", nm), m_ack, e_ack);
            chk($sformatf("%s_merr", nm), m_err, e_err);
            chk($sformatf("%s_rdata", nm), m_rdata, e_rdata);
            chk($sformatf("%s_lat", nm), n, e_lat);
            chk($sformatf("%s_xfer_cycles", nm), nx, e_lat - 1);
            chk($sformatf("%s_sreq_done", nm), s_req, 0);
            chk($sformatf("%s_busy_done", nm), busy, 1);
        end
    endtask

    task automatic rand_master(input int i);
        int sel;
        sel = $urandom_range(0, 5);
        set_mst(i, 1'($urandom_range(0, 1)), {4'(sel), 20'($urandom)}, 16'($urandom));
    endtask

    initial begin
        logic [NM-1:0] ea;
        logic [NS-1:0] es;
        int            order[6];
        int            rr;
        int            g;
        int            sel;
        int            lat;
        logic          err;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;

        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        set_slaves(0, '0);

        vecs[0] = '{0, 1'b0, 24'h100042, 16'h0000, 0,    16'hBEEF, 4'b0010, 20'h00042, 1'b0, 16'hBEEF, 2};
        vecs[1] = '{1, 1'b1, 24'h3000FF, 16'h1234, 5,    16'hAAAA, 4'b1000, 20'h000FF, 1'b0, 16'h0000, 7};
        vecs[2] = '{2, 1'b0, 24'h500000, 16'h0000, 0,    16'h1111, 4'b0000, 20'h00000, 1'b1, 16'h0000, 1};
        vecs[3] = '{3, 1'b0, 24'h200010, 16'h0000, 1000, 16'h7777, 4'b0100, 20'h00010, 1'b1, 16'h0000, 9};
        vecs[4] = '{0, 1'b0, 24'h200020, 16'h0000, 7,    16'h5A5A, 4'b0100, 20'h00020, 1'b0, 16'h5A5A, 9};
        vecs[5] = '{3, 1'b1, 24'h0ABCDE, 16'hC0DE, 2,    16'h9999, 4'b0001, 20'hABCDE, 1'b0, 16'h0000, 4};
        vecs[6] = '{1, 1'b0, 24'hF00001, 16'h0000, 0,    16'h2222, 4'b0000, 20'h00000, 1'b1, 16'h0000, 1};

        // Reset state, including a request presented while reset is held.
        #1 rst_ = 1'b0;
        m_req = 4'b0001;
        repeat (3) @(negedge clk1_50);
        chk("rst_mack", m_ack, 0);
        chk("rst_merr", m_err, 0);
        chk("rst_mrdata", m_rdata, 0);
        chk("rst_sreq", s_req, 0);
        chk("rst_swe", s_we, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_busy", busy, 0);
        m_req = '0;
        rst_  = 1'b1;
        @(negedge clk1_50);

        // Single-master vectors.
        for (int v = 0; v < NV; v++) begin
            set_slaves(vecs[v].wt, vecs[v].sdata);
            set_mst(vecs[v].mst, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            ea = '0;
            ea[vecs[v].mst] = 1'b1;
            m_req = ea;
            wait_ack($sformatf("vec%0d", v), ea, vecs[v].e_err, vecs[v].e_rdata, vecs[v].e_lat,
                     vecs[v].e_sreq, vecs[v].e_saddr, vecs[v].we, vecs[v].wdata);
            m_req = '0;
            @(negedge clk1_50);
        end

        // Round robin with all four masters holding their requests.
        do_reset();
        set_slaves(0, '0);
        for (int i = 0; i < NM; i++) begin
            set_mst(i, 1'b0, {4'(i), 20'(i)}, 16'h0000);
            slv_data[i] = 16'(32'h1000 + i);
        end
        order = '{0, 1, 2, 3, 0, 1};
        m_req = 4'hF;
        for (int j = 0; j < 6; j++) begin
            g  = order[j];
            ea = '0;
            ea[g] = 1'b1;
            es = '0;
            es[g] = 1'b1;
            wait_ack($sformatf("rr%0d", j), ea, 1'b0, 16'(32'h1000 + g), 2, es, 20'(g), 1'b0, 16'h0000);
            if (j == 5) m_req = 4'b0101;
            @(negedge clk1_50);
        end
        wait_ack("rr_skip", 4'b0100, 1'b0, 16'h1002, 2, 4'b0100, 20'h2, 1'b0, 16'h0000);
        m_req = '0;
        @(negedge clk1_50);

        // Stray acks outside XFER and from unselected slaves; request dropped mid-access.
        set_slaves(3, 16'h3333);
        ack_force = 4'b1011;
        @(negedge clk1_50);
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_mack", m_ack, 0);
        set_mst(0, 1'b0, 24'h200123, 16'h0000);
        m_req = 4'b0001;
        @(negedge clk1_50);
        @(negedge clk1_50);
        chk("middrop_sreq", s_req, 4'b0100);
        m_req = '0;
        wait_ack("middrop", 4'b0001, 1'b0, 16'h3333, 3, 4'b0100, 20'h00123, 1'b0, 16'h0000);
        ack_force = '0;
        @(negedge clk1_50);

        // Reset in the middle of an access to a dead slave.
        set_slaves(1000, '0);
        set_mst(2, 1'b0, 24'h100000, 16'h0000);
        m_req = 4'b0100;
        repeat (3) @(negedge clk1_50);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_sreq", s_req, 4'b0010);
        #2 rst_ = 1'b0;
        #1;
        chk("midrst_sreq", s_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mack", m_ack, 0);
        m_req = '0;
        @(negedge clk1_50);
        @(negedge clk1_50);
        set_slaves(0, 16'h4444);
        set_mst(1, 1'b0, 24'h000001, 16'h0000);
        set_mst(3, 1'b0, 24'h000003, 16'h0000);
        m_req = 4'b1010;
        rst_  = 1'b1;
        wait_ack("post_rst_m1", 4'b0010, 1'b0, 16'h4444, 2, 4'b0001, 20'h1, 1'b0, 16'h0000);
        m_req = 4'b1000;
        @(negedge clk1_50);
        wait_ack("post_rst_m3", 4'b1000, 1'b0, 16'h4444, 2, 4'b0001, 20'h3, 1'b0, 16'h0000);
        m_req = '0;
        @(negedge clk1_50);

        // Randomized traffic against a transaction-level model.
        do_reset();
        rr = 0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < NM; i++) begin
                if (!m_req[i] && $urandom_range(0, 2) == 0) begin
                    rand_master(i);
                    m_req[i] = 1'b1;
                end
            end
            if (m_req == '0) begin
                g = $urandom_range(0, NM - 1);
                rand_master(g);
                m_req[g] = 1'b1;
            end
            for (int k = 0; k < NS; k++) begin
                case ($urandom_range(0, 9))
                    6:       slv_wait[k] = TO - 1;
                    7:       slv_wait[k] = TO;
                    8:       slv_wait[k] = 1000;
                    default: slv_wait[k] = $urandom_range(0, 3);
                endcase
                slv_data[k] = 16'($urandom);
            end
            g = -1;
            for (int k = 0; k < NM; k++) begin
                if (g < 0 && m_req[(rr + k) % NM]) g = (rr + k) % NM;
            end
            rr  = (g + 1) % NM;
            a   = m_addr[g*AW +: AW];
            sel = int'(a[AW-1 -: SW]);
            ea  = '0;
            ea[g] = 1'b1;
            es  = '0;
            if (sel >= NS) begin
                lat = 1;
                err = 1'b1;
                rd  = '0;
            end else if (slv_wait[sel] < TO) begin
                es[sel] = 1'b1;
                lat = 2 + slv_wait[sel];
                err = 1'b0;
                rd  = m_we[g] ? 16'h0000 : slv_data[sel];
            end else begin
                es[sel] = 1'b1;
                lat = TO + 1;
                err = 1'b1;
                rd  = '0;
            end
            wait_ack($sformatf("rnd%0d", t), ea, err, rd, lat, es, a[19:0], m_we[g],
                     m_wdata[g*DW +: DW]);
            m_req[g] = 1'b0;
            @(negedge clk1_50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
